// File: rtl/interval_scheduler_pkg.sv
// Shared state encoding and reset-pointer constant for interval_scheduler.
package interval_scheduler_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_RUN  = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_t;

    // Pointer resets this far below NUM_REQ so that requester 0 is searched first.
    localparam int RST_PTR_OFFSET = 1;

    function automatic int reset_ptr(input int num_req);
        return num_req - RST_PTR_OFFSET;
    endfunction

endpackage

// File: rtl/interval_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner searched from the index after ptr.
module rr_arbiter
    import interval_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] win,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_s;

    // Walk the ring starting just past ptr; the first pending request wins.
    always_comb begin
        grant  = {NUM_REQ{1'b0}};
        win    = {IDX_W{1'b0}};
        valid  = 1'b0;
        cand_s = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand_s]) begin
                valid         = 1'b1;
                grant[cand_s] = 1'b1;
                win           = cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/interval_scheduler.sv
// One shared interval down-counter served round-robin to NUM_REQ requesters.
// Optional cancel port enabled by defining INTERVAL_SCHED_ABORT_EN.
module interval_scheduler
    import interval_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef INTERVAL_SCHED_ABORT_EN
    input  logic [NUM_REQ-1:0]         abort,
`endif
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   delay,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [WIDTH-1:0]           count
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] RST_PTR = IDX_W'(reset_ptr(NUM_REQ));
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    sched_state_t       state_r;
    sched_state_t       state_nx_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] done_r;
    logic [WIDTH-1:0]   count_r;
    logic [NUM_REQ-1:0] arb_grant_s;
    logic [IDX_W-1:0]   arb_win_s;
    logic               arb_valid_s;
    logic [WIDTH-1:0]   win_delay_s;
    logic               expire_s;
    logic               abort_hit_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .win   (arb_win_s),
        .valid (arb_valid_s)
    );

`ifdef INTERVAL_SCHED_ABORT_EN
    assign abort_hit_s = |(abort & grant_r);
`else
    assign abort_hit_s = 1'b0;
`endif

    assign expire_s = en && (count_r == {WIDTH{1'b0}});

    // Pick the winning requester's delay slice.
    always_comb begin
        win_delay_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s[i]) begin
                win_delay_s = delay[i*WIDTH +: WIDTH];
            end else begin
                win_delay_s = win_delay_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SCHED_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; a cancel by the owner takes precedence over expiry.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SCHED_IDLE: begin
                if (arb_valid_s) state_nx_s = SCHED_RUN;
                else             state_nx_s = SCHED_IDLE;
            end
            SCHED_RUN: begin
                if (abort_hit_s)   state_nx_s = SCHED_IDLE;
                else if (expire_s) state_nx_s = SCHED_DONE;
                else               state_nx_s = SCHED_RUN;
            end
            SCHED_DONE: state_nx_s = SCHED_IDLE;
            default:    state_nx_s = SCHED_IDLE;
        endcase
    end

    // Counter, grant, done pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
            grant_r <= {NUM_REQ{1'b0}};
            done_r  <= {NUM_REQ{1'b0}};
            ptr_r   <= RST_PTR;
        end else begin
            case (state_r)
                SCHED_IDLE: begin
                    done_r <= {NUM_REQ{1'b0}};
                    if (arb_valid_s) begin
                        grant_r <= arb_grant_s;
                        count_r <= win_delay_s;
                        ptr_r   <= arb_win_s;
                    end else begin
                        grant_r <= {NUM_REQ{1'b0}};
                        count_r <= {WIDTH{1'b0}};
                    end
                end
                SCHED_RUN: begin
                    if (abort_hit_s) begin
                        grant_r <= {NUM_REQ{1'b0}};
                        count_r <= {WIDTH{1'b0}};
                        done_r  <= {NUM_REQ{1'b0}};
                    end else if (expire_s) begin
                        done_r  <= grant_r;
                        grant_r <= {NUM_REQ{1'b0}};
                        count_r <= {WIDTH{1'b0}};
                    end else if (en) begin
                        count_r <= count_r - CNT_ONE;
                    end else begin
                        count_r <= count_r;
                    end
                end
                SCHED_DONE: begin
                    done_r  <= {NUM_REQ{1'b0}};
                    grant_r <= {NUM_REQ{1'b0}};
                    count_r <= {WIDTH{1'b0}};
                end
                default: begin
                    done_r  <= {NUM_REQ{1'b0}};
                    grant_r <= {NUM_REQ{1'b0}};
                    count_r <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign done  = done_r;
    assign count = count_r;
    assign busy  = (state_r != SCHED_IDLE);

endmodule
